// File: rtl/muldiv_iter_unit_if.sv
// Request/result bundle between the execute stage and the iterative HI/LO unit.
// The master drives the request side; the slave (the unit) drives HI/LO and status.
interface muldiv_iter_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       ctrl;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             cancel;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, ctrl, src_a, src_b, cancel,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, ctrl, src_a, src_b, cancel,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/muldiv_iter_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with sign fix-up, multiply-accumulate and MTHI/MTLO.
module muldiv_iter_unit #(
    parameter int WIDTH   = 32,
    parameter bit MADD_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    muldiv_iter_unit_if.slave bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_MADD  = 3'd7;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   hi_reg, hi_next;
    logic [WIDTH-1:0]   lo_reg, lo_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic [2:0]         op_reg, op_next;
    logic [WIDTH-1:0]   opnd_reg, opnd_next;
    logic [WIDTH-1:0]   a_raw_reg, a_raw_next;
    logic [2*WIDTH-1:0] acc_reg, acc_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               neg_q_reg, neg_q_next;
    logic               neg_r_reg, neg_r_next;
    logic               b_zero_reg, b_zero_next;

    logic               op_valid, accept, is_signed, is_mul_req, is_div_op;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_step;
    logic [2*WIDTH-1:0] prod_fix, madd_sum;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic               unused_div_bit;

    // Request decode and operand magnitudes
    assign op_valid   = (bus.ctrl inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU}) ||
                        (MADD_EN && bus.ctrl == OP_MADD);
    assign accept     = (state_reg == IDLE) && bus.start && !bus.cancel && op_valid;
    assign is_signed  = (bus.ctrl == OP_MULT) || (bus.ctrl == OP_DIV) || (bus.ctrl == OP_MADD);
    assign is_mul_req = (bus.ctrl == OP_MULT) || (bus.ctrl == OP_MULTU) || (bus.ctrl == OP_MADD);
    assign a_neg      = is_signed && bus.src_a[WIDTH-1];
    assign b_neg      = is_signed && bus.src_b[WIDTH-1];
    assign a_mag      = a_neg ? (~bus.src_a + 1'b1) : bus.src_a;
    assign b_mag      = b_neg ? (~bus.src_b + 1'b1) : bus.src_b;
    assign is_div_op  = (op_reg == OP_DIV) || (op_reg == OP_DIVU);

    // Multiply: acc holds {partial product, remaining multiplier bits}
    assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, (acc_reg[0] ? opnd_reg : '0)};
    assign mul_step = {mul_sum, acc_reg[WIDTH-1:1]};

    // Divide: acc holds {partial remainder, dividend bits / quotient bits}
    assign div_shift      = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    assign div_diff       = {1'b0, div_shift} - {2'b00, opnd_reg};
    assign div_ge         = !div_diff[WIDTH+1];
    assign div_rem        = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_step       = {div_rem, acc_reg[WIDTH-2:0], div_ge};
    assign unused_div_bit = div_diff[WIDTH];

    // Sign fix-up; the most-negative / -1 overflow wraps naturally to {0, most-negative}
    assign prod_fix = neg_q_reg ? (~acc_reg + 1'b1) : acc_reg;
    assign madd_sum = {hi_reg, lo_reg} + prod_fix;
    assign quo_fix  = neg_q_reg ? (~acc_reg[WIDTH-1:0] + 1'b1) : acc_reg[WIDTH-1:0];
    assign rem_fix  = neg_r_reg ? (~acc_reg[2*WIDTH-1:WIDTH] + 1'b1) : acc_reg[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            hi_reg     <= '0;
            lo_reg     <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            op_reg     <= '0;
            opnd_reg   <= '0;
            a_raw_reg  <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            b_zero_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            op_reg     <= op_next;
            opnd_reg   <= opnd_next;
            a_raw_reg  <= a_raw_next;
            acc_reg    <= acc_next;
            cnt_reg    <= cnt_next;
            neg_q_reg  <= neg_q_next;
            neg_r_reg  <= neg_r_next;
            b_zero_reg <= b_zero_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (accept) state_next = CALC;
            CALC: begin
                if (bus.cancel)          state_next = IDLE;
                else if (cnt_reg == '0)  state_next = FIX;
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        hi_next     = hi_reg;
        lo_next     = lo_reg;
        busy_next   = busy_reg;
        done_next   = 1'b0;
        op_next     = op_reg;
        opnd_next   = opnd_reg;
        a_raw_next  = a_raw_reg;
        acc_next    = acc_reg;
        cnt_next    = cnt_reg;
        neg_q_next  = neg_q_reg;
        neg_r_next  = neg_r_reg;
        b_zero_next = b_zero_reg;
        unique case (state_reg)
            IDLE: begin
                if (accept) begin
                    op_next     = bus.ctrl;
                    a_raw_next  = bus.src_a;
                    opnd_next   = is_mul_req ? a_mag : b_mag;
                    acc_next    = {{WIDTH{1'b0}}, (is_mul_req ? b_mag : a_mag)};
                    cnt_next    = CNT_W'(WIDTH - 1);
                    neg_q_next  = a_neg ^ b_neg;
                    neg_r_next  = a_neg;
                    b_zero_next = (bus.src_b == '0);
                    busy_next   = 1'b1;
                end else if (bus.start && !bus.cancel && bus.ctrl == OP_MTHI) begin
                    hi_next = bus.src_a;
                end else if (bus.start && !bus.cancel && bus.ctrl == OP_MTLO) begin
                    lo_next = bus.src_a;
                end
            end
            CALC: begin
                if (bus.cancel) begin
                    busy_next = 1'b0;
                end else begin
                    acc_next = is_div_op ? div_step : mul_step;
                    if (cnt_reg != '0) cnt_next = cnt_reg - 1'b1;
                end
            end
            FIX: begin
                busy_next = 1'b0;
                if (!bus.cancel) begin
                    done_next = 1'b1;
                    if (op_reg == OP_MADD) begin
                        {hi_next, lo_next} = madd_sum;
                    end else if (is_div_op) begin
                        if (b_zero_reg) begin
                            hi_next = a_raw_reg;
                            lo_next = '1;
                        end else begin
                            hi_next = rem_fix;
                            lo_next = quo_fix;
                        end
                    end else begin
                        {hi_next, lo_next} = prod_fix;
                    end
                end
            end
            default: busy_next = 1'b0;
        endcase
    end

    assign bus.hi   = hi_reg;
    assign bus.lo   = lo_reg;
    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Bench for muldiv_iter_unit: vector table plus randomised ops scored through a
// result queue, and hand-written MTHI/MTLO, cancel and async-reset sequences.
module tb_muldiv_iter_unit;
    localparam int W = 32;

    typedef struct {
        logic [2:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    logic clk;
    logic reset;
    muldiv_iter_unit_if #(.WIDTH(W)) bus();

    muldiv_iter_unit #(.WIDTH(W), .MADD_EN(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] sb_q[$];
    logic [63:0] model_hl;
    logic [63:0] mon_exp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] hl);
        longint      sa, sb;
        int          ia, ib;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ia = $signed(a);
        ib = $signed(b);
        case (op)
            3'd1: r = 64'(sa * sb);
            3'd2: r = {32'd0, a} * {32'd0, b};
            3'd3: begin
                if (b == 32'd0)                                 r = {a, 32'hFFFFFFFF};
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = {32'd0, 32'h80000000};
                else                                             r = {32'(ia % ib), 32'(ia / ib)};
            end
            3'd4: begin
                if (b == 32'd0) r = {a, 32'hFFFFFFFF};
                else            r = {a % b, a / b};
            end
            3'd7: r = hl + 64'(sa * sb);
            default: r = hl;
        endcase
        return r;
    endfunction

    // Scoreboard: every done pulse must match the oldest expected result
    always @(negedge clk) begin
        if (bus.done) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got hi=%h lo=%h, expected no done", bus.hi, bus.lo);
            end else begin
                mon_exp = sb_q.pop_front();
                check("result", {bus.hi, bus.lo}, mon_exp);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the done pulse
    task automatic run_arith(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [63:0] exp);
        int n;
        int bcnt;
        bus.start = 1'b1;
        bus.ctrl  = op;
        bus.src_a = a;
        bus.src_b = b;
        sb_q.push_back(exp);
        model_hl = exp;
        @(negedge clk);
        bus.start = 1'b0;
        bus.ctrl  = 3'd0;
        n    = 0;
        bcnt = 0;
        while (!bus.done && n < W + 8) begin
            if (bus.busy) bcnt++;
            @(negedge clk);
            n++;
        end
        check("latency", 64'(n), 64'(W + 1));
        check("busy_cycles", 64'(bcnt), 64'(W + 1));
        check("busy_clear", 64'(bus.busy), 64'd0);
        @(negedge clk);
        check("done_pulse", 64'(bus.done), 64'd0);
    endtask

    vec_t        vecs[13];
    logic [2:0]  rand_ops[5];
    logic [2:0]  op;
    logic [31:0] ra, rb;
    int          n;

    initial begin
        vecs[0]  = '{3'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2]  = '{3'd7, 32'h00000002, 32'h00000003, 32'hFFFFFFFE, 32'h00000007};
        vecs[3]  = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4]  = '{3'd4, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
        vecs[5]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[6]  = '{3'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[7]  = '{3'd3, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[8]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[9]  = '{3'd1, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001};
        vecs[10] = '{3'd4, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
        vecs[11] = '{3'd7, 32'hFFFFFFFF, 32'h00000001, 32'h0000000F, 32'h0FFFFFFE};
        vecs[12] = '{3'd2, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        rand_ops = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd7};

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.ctrl  = 3'd0;
        bus.src_a = '0;
        bus.src_b = '0;
        bus.cancel = 1'b0;
        model_hl  = '0;
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        check("reset_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            $display("vec %0d: ctrl=%0d a=%h b=%h -> hi=%h lo=%h",
                     i, vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
            run_arith(vecs[i].ctrl, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo});
        end

        for (int i = 0; i < 8; i++) begin
            op = rand_ops[$urandom_range(0, 4)];
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            $display("rand %0d: ctrl=%0d a=%h b=%h", i, op, ra, rb);
            run_arith(op, ra, rb, model(op, ra, rb, model_hl));
        end

        // MTHI then MTLO back to back
        bus.start = 1'b1; bus.ctrl = 3'd5; bus.src_a = 32'h12345678;
        @(negedge clk);
        check("mthi_hilo", {bus.hi, bus.lo}, {32'h12345678, model_hl[31:0]});
        check("mthi_busy", 64'(bus.busy), 64'd0);
        bus.ctrl = 3'd6; bus.src_a = 32'h9ABCDEF0;
        @(negedge clk);
        bus.start = 1'b0; bus.ctrl = 3'd0;
        check("mtlo_hilo", {bus.hi, bus.lo}, {32'h12345678, 32'h9ABCDEF0});
        check("mtlo_busy", 64'(bus.busy), 64'd0);
        model_hl = {32'h12345678, 32'h9ABCDEF0};
        $display("mthi/mtlo: hi=%h lo=%h", bus.hi, bus.lo);

        // Nop and idle cancel leave state alone
        bus.start = 1'b1; bus.ctrl = 3'd0; bus.src_a = 32'hFFFFFFFF;
        @(negedge clk);
        bus.start = 1'b0; bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        check("nop_idle_cancel", {bus.hi, bus.lo}, model_hl);
        check("nop_busy", 64'(bus.busy), 64'd0);

        // MTHI while a DIVU is in flight is dropped
        bus.start = 1'b1; bus.ctrl = 3'd4; bus.src_a = 32'd100; bus.src_b = 32'd7;
        sb_q.push_back({32'd2, 32'd14});
        @(negedge clk);
        bus.ctrl = 3'd0; bus.start = 1'b0;
        repeat (3) @(negedge clk);
        bus.start = 1'b1; bus.ctrl = 3'd5; bus.src_a = 32'hDEADBEEF;
        @(negedge clk);
        bus.start = 1'b0; bus.ctrl = 3'd0;
        check("mthi_busy_ignored", {bus.hi, 31'd0, bus.busy}, {32'h12345678, 32'd1});
        n = 0;
        while (!bus.done && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("div_done_seen", 64'(bus.done), 64'd1);
        @(negedge clk);
        check("div_wins", {bus.hi, bus.lo}, {32'd2, 32'd14});
        model_hl = {32'd2, 32'd14};
        $display("div under mthi: hi=%h lo=%h", bus.hi, bus.lo);

        // Cancel at cycle 10 with a simultaneous start that must be ignored
        bus.start = 1'b1; bus.ctrl = 3'd4; bus.src_a = 32'd1000; bus.src_b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0; bus.ctrl = 3'd0;
        repeat (9) @(negedge clk);
        check("busy_before_cancel", 64'(bus.busy), 64'd1);
        bus.cancel = 1'b1; bus.start = 1'b1; bus.ctrl = 3'd1;
        bus.src_a = 32'd5; bus.src_b = 32'd5;
        @(negedge clk);
        bus.cancel = 1'b0; bus.start = 1'b0; bus.ctrl = 3'd0;
        check("cancel_busy", 64'(bus.busy), 64'd0);
        check("cancel_hilo", {bus.hi, bus.lo}, model_hl);
        $display("cancel: hi=%h lo=%h busy=%b", bus.hi, bus.lo, bus.busy);
        run_arith(3'd1, 32'd6, 32'hFFFFFFF9, {32'hFFFFFFFF, 32'hFFFFFFD6});

        // Asynchronous reset in the middle of CALC
        bus.start = 1'b1; bus.ctrl = 3'd2; bus.src_a = 32'd9; bus.src_b = 32'd9;
        @(negedge clk);
        bus.start = 1'b0; bus.ctrl = 3'd0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_reset_hilo", {bus.hi, bus.lo}, 64'd0);
        check("async_reset_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
        $display("async reset: hi=%h lo=%h busy=%b", bus.hi, bus.lo, bus.busy);
        @(negedge clk);
        reset = 1'b1;
        model_hl = '0;
        run_arith(3'd2, 32'd3, 32'd5, {32'd0, 32'd15});

        repeat (3) @(negedge clk);
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/muldiv_iter_unit.md
Name: muldiv_iter_unit

Overview:
Parametrised, iterative successor of the HI/LO multiply/divide unit in the execute stage. It computes signed/unsigned multiply, multiply-accumulate and divide one bit per cycle into architectural HI/LO registers, and services MTHI/MTLO. It exposes busy/done to the hazard unit and a cancel input for exception flush. Every result corner case is defined.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits, product is 2*WIDTH.
MADD_EN, 1, 1 enables op 7 (signed multiply-accumulate); 0 makes op 7 a no-op.

Ports:
clk  in  1  clock, all state changes on rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  request; ctrl/src_a/src_b sampled on the edge where start=1.
ctrl  in  3  0 nop, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD.
src_a  in  WIDTH  multiplicand/dividend, or MTHI/MTLO data.
src_b  in  WIDTH  multiplier/divisor.
cancel  in  1  abort the in-flight op; HI/LO keep their pre-op values.
hi  out  WIDTH  HI register.
lo  out  WIDTH  LO register.
busy  out  1  high while an op is in flight.
done  out  1  one-cycle pulse on the edge HI/LO take an arithmetic result.

Behaviour:
- reset=0, at any time and including mid-op: hi=0, lo=0, busy=0, done=0, FSM=IDLE, all iteration state cleared.
- FSM states: IDLE, CALC, FIX.
- IDLE to CALC: start=1, ctrl in {1,2,3,4} (or 7 with MADD_EN=1), cancel=0.
  - Operands are latched.
  - Signed ops convert operands to magnitudes and record the result signs.
  - Bit counter loads WIDTH-1.
  - busy=1 from this edge.
- CALC lasts exactly WIDTH cycles.
  - Multiply: shift-add, one multiplier bit per cycle, into a 2*WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle.
  - Counter 0 moves to FIX.
- FIX lasts 1 cycle. It applies the sign correction (and the MADD addition), writes hi/lo, pulses done=1, returns to IDLE, and clears busy on the same edge.
- Latency: result is visible WIDTH+1 edges after the accept edge (33 for WIDTH=32), with busy high for all of those cycles.
- MTHI/MTLO with start=1, busy=0, cancel=0: hi (or lo) <= src_a on that edge. No busy, no done, other half unchanged.
- start while busy=1: ignored, including MTHI/MTLO. The hazard unit stalls on busy.
- cancel=1 while busy: FSM goes to IDLE and busy=0 next edge, hi/lo unchanged, no done. A start in the same cycle is ignored. cancel while idle has no effect.
- MULT: {hi,lo} = signed 2*WIDTH product.
- MULTU: {hi,lo} = unsigned 2*WIDTH product.
- MADD: {hi,lo} <= {hi,lo} + signed product, modulo 2^(2*WIDTH). The old {hi,lo} is read at FIX, not at accept.
- DIV/DIVU: lo = quotient, truncated toward zero; hi = remainder, with the sign of the dividend.
- Divide by zero (signed or unsigned): lo = all ones, hi = src_a. Full latency still applies.
- Signed overflow (src_a = most-negative, src_b = -1): lo = most-negative, hi = 0.
- Nop (ctrl=0), or op 7 with MADD_EN=0: no state change.
- Outputs are registered; there is no combinational path from inputs to hi/lo/busy/done.

Test Plan:
- MULT src_a=0xFFFFFFFE (-2), src_b=0x00000003 -> after 33 edges hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulses once, busy high for exactly 33 cycles.
- MULTU src_a=0xFFFFFFFF, src_b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then MADD src_a=2, src_b=3 -> hi=0xFFFFFFFE, lo=0x00000007.
- DIV src_a=0xFFFFFFF9 (-7), src_b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/0 -> lo=0xFFFFFFFF, hi=0x00000007. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles -> hi/lo update one edge each, busy never rises. MTHI issued while a DIV is busy -> ignored, and the DIV result wins.
- Start DIVU, assert cancel at cycle 10 -> busy drops next edge, hi/lo equal their pre-op values, no done. A new MULT accepted the cycle after completes normally.
- Assert reset low mid-CALC at cycle 5 -> hi=lo=0 and busy=0 immediately, without waiting for a clock edge. Release reset, then MULTU 3*5 -> lo=15, hi=0.
